lc3_mem_trace_buffer: RTL and testbench
=======================================

Name: lc3_mem_trace_buffer

Overview:
Synthesizable, parametrised memory-access trace recorder for the LC-3 datapath. Sits beside memory_control and taps the same internal signals the bench adapter binds to: write_en, read_en, mar_q, mdr_q, mem_rdata and ready. Records every completed access inside a programmable address window into an on-chip FIFO, tagged with a sequence number. A valid/ready drain port lets a bench, debug UART or scoreboard unload the trace. Supersedes the bench-only memory tap with a window filter, stop/overwrite modes and overflow accounting.

Parameters:
ADDR_W, 16, address width (MAR width)
DATA_W, 16, data width (MDR / memory word)
DEPTH, 16, FIFO entries; power of two, >= 2
WRAP_MODE, 0, 0 = stop-when-full (drop newest), 1 = overwrite oldest

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
cap_en  in  1  capture enable
clear  in  1  synchronous flush of FIFO, counters and flags
win_lo  in  ADDR_W  inclusive lower bound of capture window
win_hi  in  ADDR_W  inclusive upper bound of capture window
read_en  in  1  memory_control read strobe
write_en  in  1  memory_control write strobe
ready  in  1  memory_control ready
mar_q  in  ADDR_W  current MAR
mdr_q  in  DATA_W  current MDR (write data)
mem_rdata  in  DATA_W  memory read data
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head
out_addr  out  ADDR_W  head address
out_data  out  DATA_W  head data
out_we  out  1  head is a write (1) or read (0)
out_seq  out  16  head sequence number
count  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: an entry was dropped or overwritten
drop_cnt  out  16  entries lost; saturates at 16'hFFFF

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, out_valid=0, overflow=0, drop_cnt=0, seq counter=0, ready_d=0. out_addr/out_data/out_we/out_seq=0 while empty.
- Completion event: ready && (read_en || write_en) && !ready_d, where ready_d is ready registered. Exactly one event per access, however long ready is held.
- Event with cap_en=1: seq counter increments (16-bit, wraps FFFF->0000) whether or not the access is in the window. Gaps in out_seq therefore reveal filtered accesses.
- Push condition: event && cap_en && win_lo <= mar_q <= win_hi (unsigned). If win_lo > win_hi, nothing is pushed.
- Entry fields: addr=mar_q; we=write_en; data=mdr_q if write_en else mem_rdata; seq = pre-increment counter value. If read_en and write_en are both 1, treat the access as a write.
- cap_en=0: no push and no seq increment. ready_d still tracks ready.
- Drain: first-word-fall-through. out_valid = (count != 0). out_* reflect the head with no added latency. Pop on out_valid && out_ready. out_* must hold stable while out_valid=1 and out_ready=0.
- Push and pop in the same cycle, not full: both occur; count unchanged.
- Full, push with pop: accepted, no overflow.
- Full, push without pop, WRAP_MODE=0: new entry dropped; overflow<=1; drop_cnt++.
- Full, push without pop, WRAP_MODE=1: oldest entry overwritten, head advances; count stays DEPTH; overflow<=1; drop_cnt++.
- clear=1: empties FIFO and zeroes overflow, drop_cnt and seq counter. Takes priority over push and pop in the same cycle.
- Pointers: log2(DEPTH) bits, natural wrap. count ranges 0..DEPTH.
- Latency: an entry is visible on out_* the cycle after its completion event.

Test Plan:
- Reset mid-capture: 3 entries buffered, assert reset=0 -> out_valid=0, count=0, overflow=0 immediately (async). After release, next access gets out_seq=0.
- Window filter: win_lo=16'h3000, win_hi=16'h300F; accesses to 2FFF, 3000, 300F, 3010 -> exactly 2 entries, addrs 3000/300F, seqs 1/2.
- Read/write data select: write mar=3001, mdr=0005 -> {we=1, data=0005}. Read mar=3001, mem_rdata=0005 -> {we=0, data=0005}. ready held 4 cycles -> one entry only.
- Stop mode, DEPTH=4: 6 in-window accesses with out_ready=0 -> count=4, seqs 0..3 retained, overflow=1, drop_cnt=2.
- Wrap mode, DEPTH=4: same stimulus -> count=4, drained seqs 2,3,4,5, overflow=1, drop_cnt=2.
- Simultaneous push/pop when full, then clear with pending push -> count unchanged at DEPTH, no overflow; clear cycle yields count=0, drop_cnt=0, next entry seq=0.

Source files
------------

// File: rtl/lc3_mem_trace_buffer.sv
// Memory-access trace recorder for the LC-3 datapath: captures completed accesses inside an
// address window into a first-word-fall-through FIFO drained through a valid/ready port.
module lc3_mem_trace_buffer #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WRAP_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cap_en,
    input  logic                     clear,
    input  logic [ADDR_W-1:0]        win_lo,
    input  logic [ADDR_W-1:0]        win_hi,
    input  logic                     read_en,
    input  logic                     write_en,
    input  logic                     ready,
    input  logic [ADDR_W-1:0]        mar_q,
    input  logic [DATA_W-1:0]        mdr_q,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_we,
    output logic [15:0]              out_seq,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PtrOne = 1;
    localparam logic [CW-1:0] CntOne = 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);
    localparam bit Wrap = (WRAP_MODE != 0);

    logic [ADDR_W-1:0] mem_addr [DEPTH];
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic              mem_we   [DEPTH];
    logic [15:0]       mem_seq  [DEPTH];

    logic          ready_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;

    logic access_done, in_win, push, pop, full, store, lost, overwrite;
    logic              entry_we;
    logic [DATA_W-1:0] entry_data;

    // One event per access: the rising edge of ready while a strobe is up.
    assign access_done = ready && (read_en || write_en) && !ready_d;
    assign in_win      = (mar_q >= win_lo) && (mar_q <= win_hi);
    assign push        = access_done && cap_en && in_win;
    assign full        = (count_q == CntFull);
    assign pop         = out_valid && out_ready;
    assign lost        = push && full && !pop;
    assign overwrite   = lost && Wrap;
    assign store       = push && (!full || pop || Wrap);

    assign entry_we   = write_en;
    assign entry_data = write_en ? mdr_q : mem_rdata;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (access_done && cap_en) begin
                seq_d = seq_q + 16'd1;
            end
            if (store) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop || overwrite) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (lost) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            // An overwrite keeps the FIFO full, so only a fresh store grows it.
            if ((store && !overwrite) && !pop) begin
                count_d = count_q + CntOne;
            end else if (!(store && !overwrite) && pop) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_d    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ready_d    <= ready;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store && !clear) begin
            mem_addr[wr_ptr_q] <= mar_q;
            mem_data[wr_ptr_q] <= entry_data;
            mem_we[wr_ptr_q]   <= entry_we;
            mem_seq[wr_ptr_q]  <= seq_q;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_addr  = out_valid ? mem_addr[rd_ptr_q] : '0;
    assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_we    = out_valid ? mem_we[rd_ptr_q] : 1'b0;
    assign out_seq   = out_valid ? mem_seq[rd_ptr_q] : 16'd0;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_lc3_mem_trace_buffer.sv
// Scoreboard bench: a stop-mode and a wrap-mode instance (DEPTH=4) share all capture stimulus;
// a behavioural model queues expected entries which are compared as each DUT drains.
module tb_lc3_mem_trace_buffer;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        we;
        logic [15:0] seq;
    } ent_t;

    logic clk = 1'b0;
    logic reset, cap_en, clear, read_en, write_en, ready;
    logic [15:0] win_lo, win_hi, mar_q, mdr_q, mem_rdata;
    logic or_s, or_w;

    logic        v_s, v_w, we_s, we_w, ovf_s, ovf_w;
    logic [15:0] a_s, a_w, d_s, d_w, sq_s, sq_w, dc_s, dc_w;
    logic [2:0]  c_s, c_w;

    ent_t        q_s[$], q_w[$];
    logic [15:0] mseq;
    logic        mo_s, mo_w;
    logic [15:0] md_s, md_w;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    lc3_mem_trace_buffer #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .WRAP_MODE(0)) u_stop (
        .clk(clk), .reset(reset), .cap_en(cap_en), .clear(clear), .win_lo(win_lo),
        .win_hi(win_hi), .read_en(read_en), .write_en(write_en), .ready(ready),
        .mar_q(mar_q), .mdr_q(mdr_q), .mem_rdata(mem_rdata), .out_valid(v_s),
        .out_ready(or_s), .out_addr(a_s), .out_data(d_s), .out_we(we_s), .out_seq(sq_s),
        .count(c_s), .overflow(ovf_s), .drop_cnt(dc_s)
    );

    lc3_mem_trace_buffer #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .cap_en(cap_en), .clear(clear), .win_lo(win_lo),
        .win_hi(win_hi), .read_en(read_en), .write_en(write_en), .ready(ready),
        .mar_q(mar_q), .mdr_q(mdr_q), .mem_rdata(mem_rdata), .out_valid(v_w),
        .out_ready(or_w), .out_addr(a_w), .out_data(d_w), .out_we(we_w), .out_seq(sq_w),
        .count(c_w), .overflow(ovf_w), .drop_cnt(dc_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q_s.delete();
        q_w.delete();
        mseq = 16'd0;
        mo_s = 1'b0;
        mo_w = 1'b0;
        md_s = 16'd0;
        md_w = 16'd0;
    endtask

    task automatic model_push(input logic w, input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] rd);
        ent_t e;
        if (!cap_en) return;
        e.addr = a;
        e.we   = w;
        e.data = w ? d : rd;
        e.seq  = mseq;
        mseq   = mseq + 16'd1;
        if (a < win_lo || a > win_hi) return;
        if (q_s.size() < 4) q_s.push_back(e);
        else begin
            mo_s = 1'b1;
            if (md_s != 16'hFFFF) md_s = md_s + 16'd1;
        end
        if (q_w.size() == 4) begin
            void'(q_w.pop_front());
            mo_w = 1'b1;
            if (md_w != 16'hFFFF) md_w = md_w + 16'd1;
        end
        q_w.push_back(e);
    endtask

    // Compare one DUT's head against the model's front entry.
    task automatic check_head(input int which, input ent_t e);
        string p;
        p = (which == 0) ? "stop" : "wrap";
        check_eq({p, ".valid"}, (which == 0) ? v_s : v_w, 1'b1);
        check_eq({p, ".addr"}, (which == 0) ? a_s : a_w, e.addr);
        check_eq({p, ".data"}, (which == 0) ? d_s : d_w, e.data);
        check_eq({p, ".we"}, (which == 0) ? we_s : we_w, e.we);
        check_eq({p, ".seq"}, (which == 0) ? sq_s : sq_w, e.seq);
    endtask

    task automatic check_status();
        check_eq("stop.count", c_s, q_s.size());
        check_eq("stop.overflow", ovf_s, mo_s);
        check_eq("stop.drop_cnt", dc_s, md_s);
        check_eq("wrap.count", c_w, q_w.size());
        check_eq("wrap.overflow", ovf_w, mo_w);
        check_eq("wrap.drop_cnt", dc_w, md_w);
        if (q_s.size() == 0) begin
            check_eq("stop.empty_valid", v_s, 1'b0);
            check_eq("stop.empty_seq", sq_s, 16'd0);
        end
        if (q_w.size() == 0) begin
            check_eq("wrap.empty_valid", v_w, 1'b0);
            check_eq("wrap.empty_seq", sq_w, 16'd0);
        end
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic access(input logic w, input logic r, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] rd, input int hold,
                          input bit pop, input bit clr);
        write_en  = w;
        read_en   = r;
        mar_q     = a;
        mdr_q     = d;
        mem_rdata = rd;
        ready     = 1'b1;
        if (pop) begin
            if (q_s.size() != 0) check_head(0, q_s.pop_front());
            if (q_w.size() != 0) check_head(1, q_w.pop_front());
            or_s = 1'b1;
            or_w = 1'b1;
        end
        if (clr) begin
            clear = 1'b1;
            model_clear();
        end else begin
            model_push(w, a, d, rd);
        end
        @(negedge clk);
        or_s  = 1'b0;
        or_w  = 1'b0;
        clear = 1'b0;
        repeat (hold - 1) @(negedge clk);
        ready    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input int which);
        ent_t e;
        bit   done;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            if (which == 0) begin
                if (q_s.size() == 0) begin
                    check_eq("stop.drained_valid", v_s, 1'b0);
                    done = 1'b1;
                end else begin
                    e = q_s.pop_front();
                    check_head(0, e);
                    or_s = 1'b1;
                end
            end else begin
                if (q_w.size() == 0) begin
                    check_eq("wrap.drained_valid", v_w, 1'b0);
                    done = 1'b1;
                end else begin
                    e = q_w.pop_front();
                    check_head(1, e);
                    or_w = 1'b1;
                end
            end
            @(negedge clk);
            or_s = 1'b0;
            or_w = 1'b0;
        end
        if (!done) check_eq("drain_bound", 1'b0, 1'b1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cap_en = 1'b1; clear = 1'b0; read_en = 1'b0; write_en = 1'b0;
        ready = 1'b0; win_lo = 16'h3000; win_hi = 16'h300F; mar_q = '0; mdr_q = '0;
        mem_rdata = '0; or_s = 1'b0; or_w = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_status();

        // Window filter: only 3000 and 300F land, with seqs 1 and 2.
        access(1'b1, 1'b0, 16'h2FFF, 16'h0001, 16'h0, 1, 1'b0, 1'b0);
        access(1'b1, 1'b0, 16'h3000, 16'h0002, 16'h0, 1, 1'b0, 1'b0);
        access(1'b0, 1'b1, 16'h300F, 16'h0, 16'hBEEF, 1, 1'b0, 1'b0);
        access(1'b1, 1'b0, 16'h3010, 16'h0004, 16'h0, 1, 1'b0, 1'b0);
        cap_en = 1'b0;
        access(1'b1, 1'b0, 16'h3005, 16'h0009, 16'h0, 1, 1'b0, 1'b0);
        cap_en = 1'b1;
        check_status();
        drain(0);
        drain(1);

        // Data select; a long ready pulse yields one entry; both strobes act as a write.
        access(1'b1, 1'b0, 16'h3001, 16'h0005, 16'h1111, 1, 1'b0, 1'b0);
        access(1'b0, 1'b1, 16'h3001, 16'h2222, 16'h0005, 4, 1'b0, 1'b0);
        access(1'b1, 1'b1, 16'h3002, 16'h00AA, 16'h00BB, 2, 1'b0, 1'b0);
        check_status();
        drain(0);
        drain(1);

        // Overflow: six accesses into a four-entry buffer with no draining.
        do_clear();
        for (int i = 0; i < 6; i++)
            access(1'b1, 1'b0, 16'h3000 + 16'(i), 16'h0011 * 16'(i), 16'h0, 1, 1'b0, 1'b0);
        check_status();
        drain(0);
        drain(1);

        // Push with pop while full, then clear alongside a pending push.
        do_clear();
        for (int i = 0; i < 4; i++)
            access(1'b1, 1'b0, 16'h3008 + 16'(i), 16'h0100 + 16'(i), 16'h0, 1, 1'b0, 1'b0);
        access(1'b0, 1'b1, 16'h300C, 16'h0, 16'h0777, 1, 1'b1, 1'b0);
        check_status();
        access(1'b1, 1'b0, 16'h300D, 16'h0888, 16'h0, 1, 1'b0, 1'b1);
        check_status();
        access(1'b1, 1'b0, 16'h300E, 16'h0999, 16'h0, 1, 1'b0, 1'b0);
        drain(0);
        drain(1);

        // Asynchronous reset while holding entries and a set overflow flag.
        do_clear();
        for (int i = 0; i < 6; i++)
            access(1'b1, 1'b0, 16'h3003, 16'h0040 + 16'(i), 16'h0, 1, 1'b0, 1'b0);
        check_status();
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check_status();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        access(1'b0, 1'b1, 16'h3004, 16'h0, 16'h5A5A, 1, 1'b0, 1'b0);
        drain(0);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
